// File: rtl/instruction_fetch_queue_if.sv
// Instruction memory request/response bus (syn/ack handshake).
// master = fetch side, slave = memory side.
interface instruction_fetch_queue_if #(
   parameter int unsigned IWIDTH   = 32,
   parameter int unsigned PC_WIDTH = 32
);
   logic                f_o_syn;
   logic [PC_WIDTH-1:0] f_o_addr;
   logic                f_i_ack;
   logic [IWIDTH-1:0]   f_i_instr;
   logic                f_i_last;

   modport master (
      output f_o_syn,
      output f_o_addr,
      input  f_i_ack,
      input  f_i_instr,
      input  f_i_last
   );

   modport slave (
      input  f_o_syn,
      input  f_o_addr,
      output f_i_ack,
      output f_i_instr,
      output f_i_last
   );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Sequential fetch with a QDEPTH-entry prefetch queue feeding decode.
// Optional FETCH_MISALIGN_EN: misaligned redirects enqueue a flagged entry.
module instruction_fetch_queue #(
   parameter int unsigned   IWIDTH   = 32,
   parameter int unsigned   PC_WIDTH = 32,
   parameter int unsigned   QDEPTH   = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned   PC_STEP  = 4
) (
   input  logic                        f_clk,
   input  logic                        f_rst,
   input  logic                        f_i_ce,
   input  logic                        f_i_stall,
   input  logic                        f_i_change_pc,
   input  logic [PC_WIDTH-1:0]         f_i_pc,
   instruction_fetch_queue_if.master   mem,
   output logic [IWIDTH-1:0]           f_o_instr,
   output logic [PC_WIDTH-1:0]         f_o_pc,
   output logic                        f_o_valid,
   output logic                        f_o_ce,
`ifdef FETCH_MISALIGN_EN
   output logic                        f_o_misalign,
`endif
   output logic [$clog2(QDEPTH):0]     f_o_count
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [PC_WIDTH-1:0] STEP  = PC_WIDTH'(PC_STEP);
   localparam logic [PC_WIDTH-1:0] ALIGN = PC_WIDTH'(PC_STEP - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_WIDTH-1:0] addr_q, addr_d;
   logic                discard_q, discard_d;
   logic [AW-1:0]       rd_q, rd_d;
   logic [AW-1:0]       wr_q, wr_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [IWIDTH-1:0]   iram_q [QDEPTH];
   logic [PC_WIDTH-1:0] pram_q [QDEPTH];

   logic                ack;
   logic                push;
   logic                pop;
   logic                valid;
   logic                room;
   logic                room_next;
   logic                issue;
   logic                tgt_mis;
   logic                cur_mis;
   logic [PC_WIDTH-1:0] tgt;

`ifdef FETCH_MISALIGN_EN
   logic                mram_q [QDEPTH];

   assign tgt     = f_i_pc;
   assign tgt_mis = |(f_i_pc & ALIGN);
   assign cur_mis = |(fetch_pc_q & ALIGN);
`else
   assign tgt     = f_i_pc & ~ALIGN;
   assign tgt_mis = 1'b0;
   assign cur_mis = 1'b0;
`endif

   // Acks outside an outstanding request are stray and ignored.
   assign ack       = (state_q == REQ) & mem.f_i_ack;
   assign valid     = (cnt_q != '0);
   assign pop       = valid & ~f_i_stall & ~f_i_change_pc;
   assign push      = ack & ~discard_q & ~f_i_change_pc;
   assign room      = (cnt_q < CW'(QDEPTH));
   assign room_next = (cnt_q < CW'(QDEPTH - 1));

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      discard_d  = discard_q;
      issue      = 1'b0;

      if (f_i_change_pc) begin
         fetch_pc_d = tgt;
         if ((state_q == REQ) && !mem.f_i_ack) begin
            discard_d = 1'b1;
         end else begin
            discard_d = 1'b0;
            if (tgt_mis) begin
               state_d = DONE;
            end else if (f_i_ce) begin
               issue = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (f_i_ce && room) begin
                  issue = 1'b1;
               end
            end
            REQ: begin
               if (mem.f_i_ack && discard_q) begin
                  discard_d = 1'b0;
                  if (cur_mis) begin
                     state_d = DONE;
                  end else if (f_i_ce && room) begin
                     issue = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (mem.f_i_ack) begin
                  fetch_pc_d = fetch_pc_q + STEP;
                  if (mem.f_i_last) begin
                     state_d = DONE;
                  end else if (f_i_ce && room_next) begin
                     issue = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (issue) begin
         state_d = REQ;
         addr_d  = fetch_pc_d;
      end
   end

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (f_i_change_pc) begin
         rd_d  = '0;
         wr_d  = AW'(tgt_mis);
         cnt_d = CW'(tgt_mis);
      end else begin
         if (pop) begin
            rd_d = rd_q + AW'(1);
         end
         if (push) begin
            wr_d = wr_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge f_clk) begin
      if (f_rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= '0;
         discard_q  <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         discard_q  <= discard_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked while the queue is empty.
   always_ff @(posedge f_clk) begin
      if (push) begin
         iram_q[wr_q] <= mem.f_i_instr;
         pram_q[wr_q] <= addr_q;
`ifdef FETCH_MISALIGN_EN
         mram_q[wr_q] <= 1'b0;
      end else if (f_i_change_pc && tgt_mis) begin
         iram_q[0] <= '0;
         pram_q[0] <= f_i_pc;
         mram_q[0] <= 1'b1;
`endif
      end
   end

   assign mem.f_o_syn  = (state_q == REQ);
   assign mem.f_o_addr = addr_q;

   assign f_o_instr = valid ? iram_q[rd_q] : '0;
   assign f_o_pc    = valid ? pram_q[rd_q] : '0;
   assign f_o_valid = valid;
   assign f_o_ce    = pop;
   assign f_o_count = cnt_q;

`ifdef FETCH_MISALIGN_EN
   assign f_o_misalign = valid ? mram_q[rd_q] : 1'b0;
`endif

endmodule
